regfile_dump_unit: RTL
======================

REGFILE_DUMP_UNIT -- requirements
Module: regfile_dump_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width (32 registers).
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, request a dump; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, cancel an in-progress dump.
REQ-007 SHALL have port first_reg, input, ADDR_WIDTH, first index to dump; latched on an accepted start.
REQ-008 SHALL have port last_reg, input, ADDR_WIDTH, final index to dump; latched on an accepted start.
REQ-009 SHALL have port rf_read_addr, output, ADDR_WIDTH, drives the register-file read port.
REQ-010 SHALL have port rf_read_data, input, DATA_WIDTH, combinational register-file read data for rf_read_addr.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port dump_valid, output, 1, dump beat available.
REQ-013 SHALL have port dump_ready, input, 1, consumer accepts the beat.
REQ-014 SHALL have port dump_index, output, ADDR_WIDTH, register index of the current beat.
REQ-015 SHALL have port dump_data, output, DATA_WIDTH, register value of the current beat.
REQ-016 SHALL have port dump_last, output, 1, current beat is last_reg.
REQ-017 SHALL have port done, output, 1, one-cycle pulse when the dump completes normally.

Function
REQ-018 SHALL implement four states: IDLE, READ, SEND, DONE.
REQ-019 IDLE with start=1 SHALL latch first_reg/last_reg, set rf_read_addr=first_reg, and go to READ.
REQ-020 READ SHALL register rf_read_data into dump_data and rf_read_addr into dump_index, assert dump_valid, and go to SEND.
REQ-021 Index 31 (XZR) SHALL always be reported with dump_data=0, whatever rf_read_data holds.
REQ-022 SEND SHALL hold dump_valid, dump_index, dump_data and dump_last stable while dump_ready=0.
REQ-023 On a SEND handshake (valid and ready) with dump_index==last_reg, the block SHALL deassert dump_valid and go to DONE.
REQ-024 On a SEND handshake otherwise, the block SHALL set rf_read_addr to (dump_index+1) mod 32, deassert dump_valid, and go to READ.
REQ-025 Index increment SHALL wrap 31 to 0, so first_reg > last_reg dumps first..31 then 0..last (first_reg == last_reg is one beat).
REQ-026 dump_last SHALL be 1 only while dump_valid=1 and dump_index==last_reg.
REQ-027 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-028 Latency:
- start accepted at edge k gives the first dump_valid after edge k+1;
- each beat SHALL cost at least 2 cycles;
- with dump_ready held high, N beats SHALL take 2N cycles, followed by the done cycle.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 abort=1 in READ, SEND or DONE SHALL force IDLE at the next edge, with dump_valid=0 and no done pulse.
REQ-031 abort SHALL take priority over a simultaneous handshake; a beat accepted in the abort cycle is the final beat.
REQ-032 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL leave the block in IDLE.

Reset
REQ-033 reset=1 at a rising edge SHALL force IDLE, from any state, including mid-dump.
REQ-034 During and after reset, until the next accepted start: busy=0, dump_valid=0, dump_last=0, done=0, dump_index=0, dump_data=0, rf_read_addr=0.
REQ-035 Reset SHALL take priority over start and abort.

Verification
REQ-036 Register file preloaded X16=20, X17=8, X18=6; start, first=16, last=18, ready=1 -> beats (16,20), (17,8), (18,6,last=1); done one cycle later; first valid 2 edges after start; no extra beats.
REQ-037 Same dump with dump_ready low for 3 cycles on beat (17,8) -> index and data held stable, beat delivered once, total latency +3 cycles.
REQ-038 X31 preloaded 0xFFFFFFFFFFFFFFFF, X0=1, X1=2; first=30, last=1 -> indices 30, 31 (data 0), 0 (data 1), 1 (data 2, last); done.
REQ-039 X2=26; first=last=2 -> single beat (2,26), dump_last=1, done pulse; start asserted during the beat ignored.
REQ-040 Full dump 0..31, abort asserted after beat 5 is accepted -> valid=0 and busy=0 next cycle, no done; a repeated reset mid-dump gives the same result; the next start dumps correctly.

Source files
------------

// File: rtl/regfile_dump_unit.sv
// Streams a contiguous (wrapping) range of register-file entries out over a
// valid/ready port, one register per beat, with abort and single-cycle done.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// READ  | rf_read_addr presented; capture read data into the beat regs
// SEND  | beat valid, held stable until the consumer takes it
// DONE  | one-cycle completion pulse, then back to IDLE
module regfile_dump_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] first_reg,
   input  logic [ADDR_WIDTH-1:0] last_reg,
   output logic [ADDR_WIDTH-1:0] rf_read_addr,
   input  logic [DATA_WIDTH-1:0] rf_read_data,
   output logic                  busy,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [ADDR_WIDTH-1:0] dump_index,
   output logic [DATA_WIDTH-1:0] dump_data,
   output logic                  dump_last,
   output logic                  done
);

   // The top index is the hardwired zero register and never reports its storage.
   localparam logic [ADDR_WIDTH-1:0] XZR_IDX = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_SEND,
      ST_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [ADDR_WIDTH-1:0] w_rd_addr_nxt;
   logic [ADDR_WIDTH-1:0] r_last;
   logic [ADDR_WIDTH-1:0] w_last_nxt;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [ADDR_WIDTH-1:0] w_idx_nxt;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] w_data_nxt;
   logic                  r_valid;
   logic                  w_valid_nxt;
   logic                  w_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_rd_addr <= '0;
         r_last    <= '0;
         r_idx     <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_addr <= w_rd_addr_nxt;
         r_last    <= w_last_nxt;
         r_idx     <= w_idx_nxt;
         r_data    <= w_data_nxt;
         r_valid   <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_rd_addr_nxt = r_rd_addr;
      w_last_nxt    = r_last;
      w_idx_nxt     = r_idx;
      w_data_nxt    = r_data;
      w_valid_nxt   = r_valid;
      w_done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_valid_nxt = 1'b0;
            if (start && !abort) begin
               w_rd_addr_nxt = first_reg;
               w_last_nxt    = last_reg;
               w_state_nxt   = ST_READ;
            end
         end
         ST_READ: begin
            if (abort) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_idx_nxt   = r_rd_addr;
               w_data_nxt  = (r_rd_addr == XZR_IDX) ? '0 : rf_read_data;
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            // Abort wins; a beat the consumer takes in this cycle is simply the last one.
            if (abort) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end else if (dump_ready) begin
               w_valid_nxt = 1'b0;
               if (r_idx == r_last) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_rd_addr_nxt = r_idx + 1'b1;
                  w_state_nxt   = ST_READ;
               end
            end
         end
         ST_DONE: begin
            w_done      = !abort;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign rf_read_addr = r_rd_addr;
   assign busy         = (r_state != ST_IDLE);
   assign dump_valid   = r_valid;
   assign dump_index   = r_idx;
   assign dump_data    = r_data;
   assign dump_last    = r_valid && (r_idx == r_last);
   assign done         = w_done;

endmodule
